gene_base_loader: RTL and testbench

GENE_BASE_LOADER -- requirements
Module: gene_base_loader

---
 rtl/gene_pkg.sv | 50 +++++
 rtl/gene_base_fifo.sv | 65 ++++++
 rtl/gene_base_loader.sv | 127 ++++++++++++
 tb/tb_gene_base_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gene_pkg.sv
// Shared definitions for the gene base loader: base codes, control characters,
// FSM state type and the host character decoder.
package gene_pkg;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    localparam logic [7:0] CH_HDR = 8'h3E;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD_PAT = 2'd1,
        ST_STREAM   = 2'd2
    } gene_state_e;

    typedef enum logic [1:0] {
        CLS_BASE = 2'd0,
        CLS_HDR  = 2'd1,
        CLS_EOL  = 2'd2,
        CLS_BAD  = 2'd3
    } char_class_e;

    function automatic char_class_e char_class(input logic [7:0] c);
        char_class_e cls;
        case (c)
            8'h41, 8'h61, 8'h43, 8'h63,
            8'h47, 8'h67, 8'h54, 8'h74: cls = CLS_BASE;
            CH_HDR:                     cls = CLS_HDR;
            CH_LF, CH_CR:               cls = CLS_EOL;
            default:                    cls = CLS_BAD;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] base_code(input logic [7:0] c);
        logic [1:0] code;
        case (c)
            8'h43, 8'h63: code = BASE_C;
            8'h47, 8'h67: code = BASE_G;
            8'h54, 8'h74: code = BASE_T;
            default:      code = BASE_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/gene_base_fifo.sv
// Small synchronous FIFO of 2-bit base codes; output reads the head entry
// directly so 'not empty' is a pure register-derived valid.
module gene_base_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [1:0] din_i,
    input  logic       pop_i,
    output logic [1:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [1:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Drive zero when empty so a freshly reset or drained FIFO shows base 0.
    assign dout_o  = empty_o ? 2'b00 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/gene_base_loader.sv
// Host character front end: parses '>' headers into a pattern register and
// streams subsequent bases through a FIFO to the gene matcher.
module gene_base_loader
    import gene_pkg::*;
#(
    parameter int PAT_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           char_in,
    input  logic                 char_valid,
    output logic                 char_ready,
    output logic [1:0]           base_out,
    output logic                 base_valid,
    input  logic                 base_ready,
    output logic [2*PAT_LEN-1:0] pat_out,
    output logic                 pat_valid,
    output logic [7:0]           bad_count,
    output logic [15:0]          base_count
);

    localparam int PW    = 2 * PAT_LEN;
    localparam int IDX_W = $clog2(PAT_LEN + 1);

    gene_state_e      state_q, state_d;
    logic [PW-1:0]    pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pat_valid_q, pat_valid_d;
    logic [7:0]       bad_q, bad_d;
    logic [15:0]      bcnt_q, bcnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             accept;
    logic             pop;
    char_class_e      cls;
    logic [1:0]       code;

    assign char_ready = !fifo_full;
    assign base_valid = !fifo_empty;
    assign accept     = char_valid && !fifo_full;
    assign pop        = base_valid && base_ready;
    assign cls        = char_class(char_in);
    assign code       = base_code(char_in);

    assign pat_out    = pat_q;
    assign pat_valid  = pat_valid_q;
    assign bad_count  = bad_q;
    assign base_count = bcnt_q;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        idx_d       = idx_q;
        pat_valid_d = pat_valid_q;
        bad_d       = bad_q;
        bcnt_d      = bcnt_q;
        fifo_push   = 1'b0;

        if (accept) begin
            case (cls)
                CLS_HDR: begin
                    state_d     = ST_LOAD_PAT;
                    idx_d       = '0;
                    pat_valid_d = 1'b0;
                    pat_d       = '0;
                end
                CLS_BASE: begin
                    if (state_q == ST_LOAD_PAT) begin
                        pat_d = {pat_q[PW-3:0], code};
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_W'(PAT_LEN - 1)) begin
                            pat_valid_d = 1'b1;
                            state_d     = ST_STREAM;
                        end
                    end else if (state_q == ST_STREAM) begin
                        fifo_push = 1'b1;
                    end
                end
                CLS_BAD: begin
                    if (bad_q != 8'hFF) begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (pop) begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            idx_q       <= '0;
            pat_valid_q <= 1'b0;
            bad_q       <= '0;
            bcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            idx_q       <= idx_d;
            pat_valid_q <= pat_valid_d;
            bad_q       <= bad_d;
            bcnt_q      <= bcnt_d;
        end
    end

    gene_base_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (code),
        .pop_i   (base_ready),
        .dout_o  (base_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_gene_base_loader.sv
// Bench for gene_base_loader: queue-level behavioural model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_gene_base_loader;

    localparam int PAT_LEN = 8;
    localparam int DEPTH   = 4;
    localparam int PW      = 2 * PAT_LEN;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    char_in;
    logic          char_valid;
    logic          char_ready;
    logic [1:0]    base_out;
    logic          base_valid;
    logic          base_ready;
    logic [PW-1:0] pat_out;
    logic          pat_valid;
    logic [7:0]    bad_count;
    logic [15:0]   base_count;

    int checks = 0;
    int errors = 0;

    // Model state
    int            m_q[$];
    int            m_mode;   // 0 idle, 1 loading pattern, 2 streaming
    int            m_idx;
    bit            m_pv;
    logic [PW-1:0] m_pat;
    int            m_bad;
    int            m_bcnt;

    int            obs[$];
    int            exp_q[$];
    bit            seen_valid;

    always #5 clk = ~clk;

    gene_base_loader #(
        .PAT_LEN    (PAT_LEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .base_out   (base_out),
        .base_valid (base_valid),
        .base_ready (base_ready),
        .pat_out    (pat_out),
        .pat_valid  (pat_valid),
        .bad_count  (bad_count),
        .base_count (base_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int enc(input logic [7:0] c);
        case (c)
            "A", "a": return 0;
            "C", "c": return 1;
            "G", "g": return 2;
            "T", "t": return 3;
            default:  return -1;
        endcase
    endfunction

    task automatic model_step();
        bit pop;
        bit acc;
        int code;
        if (rst) begin
            m_q.delete();
            m_mode = 0; m_idx = 0; m_pv = 0; m_pat = '0; m_bad = 0; m_bcnt = 0;
            return;
        end
        pop = (m_q.size() > 0) && base_ready;
        acc = char_valid && (m_q.size() < DEPTH);
        if (pop) begin
            void'(m_q.pop_front());
            m_bcnt = (m_bcnt + 1) % 65536;
        end
        if (acc) begin
            code = enc(char_in);
            if (char_in == 8'h3E) begin
                m_mode = 1; m_idx = 0; m_pv = 0; m_pat = '0;
            end else if (code >= 0) begin
                if (m_mode == 1) begin
                    m_pat = (m_pat << 2) | PW'(code);
                    m_idx++;
                    if (m_idx == PAT_LEN) begin
                        m_pv = 1;
                        m_mode = 2;
                    end
                end else if (m_mode == 2) begin
                    m_q.push_back(code);
                end
            end else if (char_in != 8'h0A && char_in != 8'h0D) begin
                if (m_bad < 255) m_bad++;
            end
        end
    endtask

    task automatic compare();
        chk("char_ready", int'(char_ready), int'(m_q.size() < DEPTH));
        chk("base_valid", int'(base_valid), int'(m_q.size() > 0));
        if (m_q.size() > 0) chk("base_out", int'(base_out), m_q[0]);
        chk("pat_valid", int'(pat_valid), int'(m_pv));
        if (m_pv) chk("pat_out", int'(pat_out), int'(m_pat));
        chk("bad_count", int'(bad_count), m_bad);
        chk("base_count", int'(base_count), m_bcnt);
    endtask

    // One clock: record handshakes, advance the model, then check after the edge.
    task automatic tick();
        if (base_valid && base_ready) obs.push_back(int'(base_out));
        if (base_valid) seen_valid = 1'b1;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        char_valid = 1'b1;
        char_in    = c;
        while (!char_ready && n < 200) begin
            tick();
            n++;
        end
        if (!char_ready) chk("send_timeout", int'(char_ready), 1);
        tick();
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic check_obs(input string name);
        chk({name, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk(name, obs[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; char_in = 8'h00; char_valid = 1'b0; base_ready = 1'b0;
        seen_valid = 1'b0;
        drain(2);
        rst = 1'b0;
        chk("rst_char_ready", int'(char_ready), 1);
        chk("rst_base_valid", int'(base_valid), 0);
        chk("rst_base_out", int'(base_out), 0);
        chk("rst_pat_out", int'(pat_out), 0);
        chk("rst_pat_valid", int'(pat_valid), 0);
        chk("rst_counts", int'(bad_count) + int'(base_count), 0);

        // Pattern load then two streamed bases
        base_ready = 1'b1;
        send_str(">ACGTACGT");
        chk("req035_pat_valid", int'(pat_valid), 1);
        chk("req035_pat_out", int'(pat_out), 'h1B1B);
        obs.delete();
        send_str("GG");
        drain(4);
        exp_q = '{2, 2};
        check_obs("req035_seq");
        chk("req035_base_count", int'(base_count), 2);

        // Backpressure: FIFO fills after 4, 5th held off
        base_ready = 1'b0;
        send_str("ACGT");
        chk("req036_ready_low", int'(char_ready), 0);
        char_valid = 1'b1;
        char_in    = "C";
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("req036_hold_out", int'(base_out), 0);
            chk("req036_hold_ready", int'(char_ready), 0);
        end
        obs.delete();
        base_ready = 1'b1;
        send_char("C");
        drain(8);
        exp_q = '{0, 1, 2, 3, 1};
        check_obs("req036_seq");
        chk("req036_base_count", int'(base_count), 7);

        // Line endings dropped silently in STREAM
        obs.delete();
        send_str("a\r\nc");
        drain(4);
        exp_q = '{0, 1};
        check_obs("req040_seq");
        chk("req040_bad", int'(bad_count), 0);

        // Reset mid-stream with 3 bases buffered
        base_ready = 1'b0;
        send_str("GTA");
        chk("req039_buffered", int'(base_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("req039_base_valid", int'(base_valid), 0);
        chk("req039_pat_valid", int'(pat_valid), 0);
        chk("req039_base_count", int'(base_count), 0);
        chk("req039_bad_count", int'(bad_count), 0);
        obs.delete();
        base_ready = 1'b1;
        send_str("AC");
        drain(4);
        chk("req039_idle_out", obs.size(), 0);
        chk("req039_idle_valid", int'(base_valid), 0);

        // Restarted header discards partial pattern
        send_str(">ACG");
        send_str(">TTTTTTTT");
        chk("req037_pat_out", int'(pat_out), 'hFFFF);
        chk("req037_pat_valid", int'(pat_valid), 1);

        // Bad character saturation, state stays STREAM
        seen_valid = 1'b0;
        for (int i = 0; i < 300; i++) send_char("X");
        chk("req038_bad", int'(bad_count), 255);
        chk("req038_no_valid", int'(seen_valid), 0);
        obs.delete();
        send_str("GA");
        drain(4);
        exp_q = '{2, 0};
        check_obs("req038_stream");
        chk("req038_pat_kept", int'(pat_out), 'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
